prf_wb_arb: RTL
===============

PRF_WB_ARB -- requirements
Module: prf_wb_arb

Interface
REQ-001 Params: CONFIG_DW, default 0, data width; CONFIG_P_WRITEBACK_WIDTH, default 0, log2 PRF write ports (WW); CONFIG_P_FU_NUM, default 0, log2 FU result ports (FN); CONFIG_P_BUF_DEPTH, default 0, log2 per-FU buffer depth (D); all set by instantiator.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 fu_wb_valid  in  FN  per-FU result valid.
REQ-005 fu_wb_ready  out  FN  per-FU buffer can accept.
REQ-006 fu_wb_we  in  FN  result has a destination register.
REQ-007 fu_wb_prd  in  FN*`NCPU_PRF_AW  destination physical register.
REQ-008 fu_wb_dat  in  FN*CONFIG_DW  result data.
REQ-009 prf_WE  out  WW  PRF write enables, registered.
REQ-010 prf_WADDR  out  WW*`NCPU_PRF_AW  PRF write addresses, registered.
REQ-011 prf_WDATA  out  WW*CONFIG_DW  PRF write data, registered.

Function
REQ-012 Handshake per FU i: transfer when fu_wb_valid[i] & fu_wb_ready[i] in the same cycle; valid carries no hold requirement.
REQ-013 fu_wb_ready[i] = buffer i occupancy < 2^D, from registered count only; no same-cycle pass-through when full, even if head dequeues that cycle.
REQ-014 Transfer with fu_wb_we=0 or fu_wb_prd=0: accepted, not stored (r0 always reads zero downstream).
REQ-015 Stored transfer enqueues at the edge ending cycle N; entry is grant-eligible in cycle N+1 at the earliest.
REQ-016 Each cycle, up to WW non-empty buffer heads granted, scanning FU indices from rr_ptr upward, modulo FN.
REQ-017 Grant k (k=0..WW-1, scan order) drives output slot k; unused slots have prf_WE[k]=0, WADDR/WDATA unspecified.
REQ-018 Granted heads dequeue and load into output registers at the same edge; a granted entry produces prf_WE during cycle N+2 relative to acceptance cycle N (minimum latency 2).
REQ-019 rr_ptr updates to (last granted index + 1) mod FN when any grant; unchanged otherwise.
REQ-020 Simultaneous enqueue and dequeue on one buffer: occupancy unchanged, both take effect.
REQ-021 Per-FU order preserved; no ordering guaranteed across FUs.
REQ-022 Pointer wrap-around in buffers at 2^D entries; occupancy counter width D+1.
REQ-023 Two slots never carry the same FU's entry in one cycle.
REQ-024 Every output written each cycle; prf_WE is low in cycles without grants.

Reset
REQ-025 On rst: all buffers empty, rr_ptr=0, prf_WE=0, prf_WADDR=0, prf_WDATA=0, fu_wb_ready all 1 after reset release.
REQ-026 Reset mid-operation discards all buffered and in-flight entries; no PRF write issued for them after rst asserts.
REQ-027 Buffer storage arrays need no reset.

Structure
REQ-028 `NCPU_PRF_AW comes from ncpu64k_config.vh; no new package constants.
REQ-029 One sub-module natural: prf_wb_fifo (single-clock FIFO, depth 2^D, width `NCPU_PRF_AW+CONFIG_DW), instantiated FN times.
REQ-030 Output registers built from codebase DFF primitives, reset-capable variant.

Verification (bench config: DW=64, WW=2, FN=4, D=2)
REQ-031 FU0 sends prd=5, dat=0xAA at cycle 1 -> prf_WE[0]=1, WADDR=5, WDATA=0xAA in cycle 3; prf_WE[1]=0.
REQ-032 All 4 FUs valid in cycle 1 (prd 1..4), rr_ptr=0 -> cycle 3 slots write prd1, prd2; cycle 4 write prd3, prd4; rr_ptr=0 afterwards.
REQ-033 FU2 sends 5 results back-to-back, no drain (other FUs hold grants) -> fu_wb_ready[2]=0 after 4 accepted; 5th held until space; all 5 reach PRF in order.
REQ-034 FU1 sends prd=0 and separately we=0 -> ready stays 1, no prf_WE produced.
REQ-035 rst asserted with 3 entries buffered -> prf_WE=0 immediately and thereafter; buffers empty, ready=1 after release.
REQ-036 Random FU traffic, 10k cycles -> scoreboard: every stored transfer written exactly once, per-FU order kept, no lost/duplicate writes.

Source files
------------

// File: rtl/prf_wb_arb_pkg.sv
// Shared helpers for the PRF writeback arbiter.
// The PRF address width normally arrives from ncpu64k_config.vh; the guarded
// fallback keeps this slice self-contained when that header is not in scope.
`ifndef NCPU_PRF_AW
`define NCPU_PRF_AW 6
`endif

package prf_wb_arb_pkg;

   // Index reached by stepping 'ofs' places from 'base' around a ring of 'n'.
   function automatic int wrap_idx(input int base, input int ofs, input int n);
      return (base + ofs) % n;
   endfunction

endpackage

// File: rtl/prf_wb_fifo.sv
// Single-clock FIFO of 2^D entries, used as one per-FU result buffer.
// full/empty come straight from the registered occupancy count, so a full
// buffer never accepts in the same cycle its head leaves.
`ifndef NCPU_PRF_AW
`define NCPU_PRF_AW 6
`endif

module prf_wb_fifo
   import prf_wb_arb_pkg::*;
#(
   parameter int W = 1,
   parameter int D = 0
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         empty,
   output logic         full
);

   localparam int DEPTH = 1 << D;
   localparam int PW    = (D > 0) ? D : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [D:0]    count;

   // Storage is written only on push; contents need no reset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   // Pointers wrap after DEPTH entries; push and pop together leave count unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= PW'(wrap_idx(int'(wr_ptr), 1, DEPTH));
         if (pop)  rd_ptr <= PW'(wrap_idx(int'(rd_ptr), 1, DEPTH));
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign dout  = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == (D+1)'(DEPTH));

endmodule

// File: rtl/prf_wb_arb.sv
// PRF writeback arbiter: buffers results from FN functional units and
// round-robin grants up to WW buffer heads per cycle onto registered PRF
// write ports (acceptance cycle N -> prf_WE in cycle N+2 at the earliest).
//
// Handshake: FU i transfers in any cycle where fu_wb_valid[i] and
// fu_wb_ready[i] are both high; valid need not be held, and ready depends
// only on the registered buffer occupancy. A transfer with no destination
// (we=0 or prd=0) is accepted and dropped.
`ifndef NCPU_PRF_AW
`define NCPU_PRF_AW 6
`endif

module prf_wb_arb
   import prf_wb_arb_pkg::*;
#(
   parameter int CONFIG_DW                = 0,
   parameter int CONFIG_P_WRITEBACK_WIDTH = 0,
   parameter int CONFIG_P_FU_NUM          = 0,
   parameter int CONFIG_P_BUF_DEPTH       = 0,
   localparam int DW = (CONFIG_DW > 0) ? CONFIG_DW : 1,
   localparam int AW = `NCPU_PRF_AW,
   localparam int WW = 1 << CONFIG_P_WRITEBACK_WIDTH,
   localparam int FN = 1 << CONFIG_P_FU_NUM
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [FN-1:0]     fu_wb_valid,
   output logic [FN-1:0]     fu_wb_ready,
   input  logic [FN-1:0]     fu_wb_we,
   input  logic [FN*AW-1:0]  fu_wb_prd,
   input  logic [FN*DW-1:0]  fu_wb_dat,
   output logic [WW-1:0]     prf_WE,
   output logic [WW*AW-1:0]  prf_WADDR,
   output logic [WW*DW-1:0]  prf_WDATA
);

   localparam int FNW = (CONFIG_P_FU_NUM > 0) ? CONFIG_P_FU_NUM : 1;
   localparam int EW  = AW + DW;

   logic [FN-1:0]    push;
   logic [FN-1:0]    pop;
   logic [FN-1:0]    empty;
   logic [FN-1:0]    full;
   logic [EW-1:0]    head [FN];
   logic [FNW-1:0]   rr_ptr;
   logic [FNW-1:0]   rr_nxt;
   logic [WW-1:0]    slot_we;
   logic [WW*AW-1:0] slot_addr;
   logic [WW*DW-1:0] slot_dat;

   for (genvar g = 0; g < FN; g++) begin : g_buf
      // Only results that actually write a non-zero register take buffer space.
      assign push[g] = fu_wb_valid[g] & ~full[g] & fu_wb_we[g]
                       & (fu_wb_prd[g*AW +: AW] != '0);

      prf_wb_fifo #(.W(EW), .D(CONFIG_P_BUF_DEPTH)) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (push[g]),
         .din   ({fu_wb_prd[g*AW +: AW], fu_wb_dat[g*DW +: DW]}),
         .pop   (pop[g]),
         .dout  (head[g]),
         .empty (empty[g]),
         .full  (full[g])
      );
   end

   assign fu_wb_ready = ~full;

   // Scan FUs from rr_ptr upward; the k-th non-empty head found fills slot k.
   always_comb begin
      int cnt;
      int idx;
      int last;
      pop       = '0;
      slot_we   = '0;
      slot_addr = '0;
      slot_dat  = '0;
      rr_nxt    = rr_ptr;
      cnt       = 0;
      idx       = 0;
      last      = 0;
      for (int k = 0; k < FN; k++) begin
         idx = wrap_idx(int'(rr_ptr), k, FN);
         if (!empty[idx] && (cnt < WW)) begin
            pop[idx]                  = 1'b1;
            slot_we[cnt]              = 1'b1;
            slot_addr[cnt*AW +: AW]   = head[idx][EW-1 -: AW];
            slot_dat[cnt*DW +: DW]    = head[idx][DW-1:0];
            last                      = idx;
            cnt                       = cnt + 1;
         end
      end
      if (cnt > 0) rr_nxt = FNW'(wrap_idx(last, 1, FN));
   end

   // Register the granted entries onto the PRF ports and advance the pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prf_WE    <= '0;
         prf_WADDR <= '0;
         prf_WDATA <= '0;
         rr_ptr    <= '0;
      end else begin
         prf_WE    <= slot_we;
         prf_WADDR <= slot_addr;
         prf_WDATA <= slot_dat;
         rr_ptr    <= rr_nxt;
      end
   end

endmodule
